// File: rtl/imm_gen_pkg.sv
// Shared opcode constants and immediate-format encoding for the decode-stage immediate generator.
package imm_gen_pkg;

    localparam logic [6:0] OP_R      = 7'b0110011;
    localparam logic [6:0] OP_IMM    = 7'b0010011;
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_JALR   = 7'b1100111;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_LUI    = 7'b0110111;
    localparam logic [6:0] OP_AUIPC  = 7'b0010111;
    localparam logic [6:0] OP_JAL    = 7'b1101111;

    localparam logic [2:0] F3_SLL = 3'b001;
    localparam logic [2:0] F3_SRX = 3'b101;

    typedef enum logic [2:0] {
        FMT_NONE  = 3'd0,
        FMT_I     = 3'd1,
        FMT_S     = 3'd2,
        FMT_B     = 3'd3,
        FMT_U     = 3'd4,
        FMT_J     = 3'd5,
        FMT_SHAMT = 3'd6
    } fmt_t;

endpackage

// File: rtl/imm_decode.sv
// Combinational RV32I immediate decoder: instruction -> sign-extended immediate, format, illegal flag.
// Every immediate is built as a 32-bit signed value, then sign-extended to XLEN by a size cast.
module imm_decode
    import imm_gen_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  logic [31:0]     instr_i,
    output logic [XLEN-1:0] imm_o,
    output fmt_t            fmt_o,
    output logic            illegal_o
);

    if (XLEN != 32 && XLEN != 64) begin : g_bad_xlen
        $error("imm_decode: XLEN must be 32 or 64");
    end

    logic [6:0]         opcode;
    logic [2:0]         funct3;
    logic               s;
    logic [5:0]         shamt;
    logic signed [31:0] imm32;

    assign opcode = instr_i[6:0];
    assign funct3 = instr_i[14:12];
    assign s      = instr_i[31];
    // RV64 shifts use a 6-bit shamt; bit 30 (arith select) never leaks in.
    assign shamt  = (XLEN == 64) ? instr_i[25:20] : {1'b0, instr_i[24:20]};

    always_comb begin
        imm32     = '0;
        fmt_o     = FMT_NONE;
        illegal_o = 1'b0;
        case (opcode)
            OP_R: ;
            OP_IMM: begin
                if (funct3 == F3_SLL || funct3 == F3_SRX) begin
                    fmt_o = FMT_SHAMT;
                    imm32 = {26'b0, shamt};
                end else begin
                    fmt_o = FMT_I;
                    imm32 = {{20{s}}, instr_i[31:20]};
                end
            end
            OP_LOAD, OP_JALR: begin
                fmt_o = FMT_I;
                imm32 = {{20{s}}, instr_i[31:20]};
            end
            OP_STORE: begin
                fmt_o = FMT_S;
                imm32 = {{20{s}}, instr_i[31:25], instr_i[11:7]};
            end
            OP_BRANCH: begin
                fmt_o = FMT_B;
                imm32 = {{20{s}}, instr_i[7], instr_i[30:25], instr_i[11:8], 1'b0};
            end
            OP_LUI, OP_AUIPC: begin
                fmt_o = FMT_U;
                imm32 = {instr_i[31:12], 12'b0};
            end
            OP_JAL: begin
                fmt_o = FMT_J;
                imm32 = {{12{s}}, instr_i[19:12], instr_i[20], instr_i[30:21], 1'b0};
            end
            default: illegal_o = 1'b1;
        endcase
    end

    assign imm_o = XLEN'(imm32);

endmodule

// File: rtl/imm_gen_stage.sv
// Decode-stage immediate generator with a 2-entry skid buffer; valid/ready on both sides, sync flush.
// in_ready_o depends only on the occupancy count, so upstream never sees a combinational path from out_ready_i.
module imm_gen_stage
    import imm_gen_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  logic            clk_i,
    input  logic            rst_i,
    input  logic            flush_i,
    input  logic            in_valid_i,
    output logic            in_ready_o,
    input  logic [31:0]     instr_i,
    output logic            out_valid_o,
    input  logic            out_ready_i,
    output logic [31:0]     instr_o,
    output logic [XLEN-1:0] imm_o,
    output fmt_t            fmt_o,
    output logic            illegal_o
);

    logic [XLEN-1:0] dec_imm;
    fmt_t            dec_fmt;
    logic            dec_ill;

    imm_decode #(.XLEN(XLEN)) u_decode (
        .instr_i   (instr_i),
        .imm_o     (dec_imm),
        .fmt_o     (dec_fmt),
        .illegal_o (dec_ill)
    );

    logic [1:0]      count_q, count_d;
    logic [31:0]     hd_instr_q, hd_instr_d, tl_instr_q, tl_instr_d;
    logic [XLEN-1:0] hd_imm_q, hd_imm_d, tl_imm_q, tl_imm_d;
    fmt_t            hd_fmt_q, hd_fmt_d, tl_fmt_q, tl_fmt_d;
    logic            hd_ill_q, hd_ill_d, tl_ill_q, tl_ill_d;
    logic            push, pop;

    assign in_ready_o  = (count_q != 2'd2);
    assign out_valid_o = (count_q != 2'd0);
    assign push        = in_valid_i && in_ready_o;
    assign pop         = out_valid_o && out_ready_i;

    always_comb begin
        count_d    = count_q;
        hd_instr_d = hd_instr_q;
        hd_imm_d   = hd_imm_q;
        hd_fmt_d   = hd_fmt_q;
        hd_ill_d   = hd_ill_q;
        tl_instr_d = tl_instr_q;
        tl_imm_d   = tl_imm_q;
        tl_fmt_d   = tl_fmt_q;
        tl_ill_d   = tl_ill_q;
        if (flush_i) begin
            count_d = 2'd0;
        end else if (push && (pop || count_q == 2'd0)) begin
            // Empty, or the only entry leaves this cycle: new entry lands in the head.
            hd_instr_d = instr_i;
            hd_imm_d   = dec_imm;
            hd_fmt_d   = dec_fmt;
            hd_ill_d   = dec_ill;
            count_d    = 2'd1;
        end else if (push) begin
            tl_instr_d = instr_i;
            tl_imm_d   = dec_imm;
            tl_fmt_d   = dec_fmt;
            tl_ill_d   = dec_ill;
            count_d    = 2'd2;
        end else if (pop) begin
            if (count_q == 2'd2) begin
                hd_instr_d = tl_instr_q;
                hd_imm_d   = tl_imm_q;
                hd_fmt_d   = tl_fmt_q;
                hd_ill_d   = tl_ill_q;
            end
            count_d = count_q - 2'd1;
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            count_q    <= 2'd0;
            hd_instr_q <= '0;
            hd_imm_q   <= '0;
            hd_fmt_q   <= FMT_NONE;
            hd_ill_q   <= 1'b0;
            tl_instr_q <= '0;
            tl_imm_q   <= '0;
            tl_fmt_q   <= FMT_NONE;
            tl_ill_q   <= 1'b0;
        end else begin
            count_q    <= count_d;
            hd_instr_q <= hd_instr_d;
            hd_imm_q   <= hd_imm_d;
            hd_fmt_q   <= hd_fmt_d;
            hd_ill_q   <= hd_ill_d;
            tl_instr_q <= tl_instr_d;
            tl_imm_q   <= tl_imm_d;
            tl_fmt_q   <= tl_fmt_d;
            tl_ill_q   <= tl_ill_d;
        end
    end

    assign instr_o   = hd_instr_q;
    assign imm_o     = hd_imm_q;
    assign fmt_o     = hd_fmt_q;
    assign illegal_o = hd_ill_q;

endmodule
